// File: rtl/phase_readout.sv
// phase_readout
//   Sweeps the sample block's phase read port, compares each counter with a
//   cutoff captured at start, packs one spin bit per counter into 32-bit
//   words and streams them out over valid/ready. Popcount of the sweep is
//   reported on o_ones_count.
//
//   state | meaning
//   IDLE  | waiting for i_start, rd_addr parked at BASE
//   READ  | one counter compared per cycle, bit written into the word
//   PUSH  | word offered on o_out_data until i_out_ready
//   DONE  | one-cycle o_done pulse, then back to IDLE
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               start a sweep (IDLE only)
//   i_counter_cutoff      threshold, captured on accepted start
//   o_rd_addr / i_phase   phase read port (combinational return)
//   o_out_data/valid/last result word stream, i_out_ready backpressure
//   o_busy, o_done        sweep status
//   o_ones_count          spin bits equal to 1 in the last sweep

`ifndef PHASE_ADDR_BASE
`define PHASE_ADDR_BASE 32'h4000_0000
`endif

module phase_readout #(
    parameter int unsigned N    = 3,
    parameter logic [31:0] BASE = `PHASE_ADDR_BASE
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_counter_cutoff,
    output logic [31:0] o_rd_addr,
    input  logic [31:0] i_phase,
    output logic [31:0] o_out_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic        o_out_last,
    output logic        o_busy,
    output logic        o_done,
    output logic [10:0] o_ones_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        PUSH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [10:0] r_idx;
    logic [31:0] r_cutoff;
    logic [31:0] r_word;
    logic [10:0] r_ones;

    logic        w_bit;
    logic        w_idx_last;
    logic        w_word_end;

    assign w_bit      = (i_phase >= r_cutoff);
    assign w_idx_last = (r_idx == 11'(N - 1));
    assign w_word_end = (r_idx[4:0] == 5'd31) || w_idx_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath. Word and popcount are only touched in READ, so out_data is
    // naturally held during PUSH stalls and ones_count holds after DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx    <= '0;
            r_cutoff <= '0;
            r_word   <= '0;
            r_ones   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_cutoff <= i_counter_cutoff;
                        r_idx    <= '0;
                        r_word   <= '0;
                        r_ones   <= '0;
                    end
                end
                READ: begin
                    r_word[r_idx[4:0]] <= w_bit;
                    r_ones             <= r_ones + 11'(w_bit);
                    if (!w_word_end) begin
                        r_idx <= r_idx + 11'd1;
                    end
                end
                PUSH: begin
                    if (i_out_ready && !w_idx_last) begin
                        r_word <= '0;
                        r_idx  <= r_idx + 11'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_out_valid = 1'b0;
        o_out_last  = 1'b0;
        o_out_data  = '0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        // r_idx is frozen in PUSH/DONE, so the address holds its last value.
        o_rd_addr   = BASE + {19'd0, r_idx, 2'b00};
        case (r_state)
            IDLE: begin
                o_busy    = 1'b0;
                o_rd_addr = BASE;
                if (i_start) begin
                    w_state_nxt = READ;
                end
            end
            READ: begin
                if (w_word_end) begin
                    w_state_nxt = PUSH;
                end
            end
            PUSH: begin
                o_out_valid = 1'b1;
                o_out_data  = r_word;
                o_out_last  = w_idx_last;
                if (i_out_ready) begin
                    w_state_nxt = w_idx_last ? DONE : READ;
                end
            end
            DONE: begin
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_ones_count = r_ones;

endmodule

// File: tb/tb_phase_readout.sv
module tb_phase_readout;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- DUT with N = 3 ----------------
    logic        rst3, start3, ready3, valid3, last3, busy3, done3;
    logic [31:0] cutoff3, rd_addr3, phase3, data3;
    logic [10:0] ones3;
    logic [31:0] mem3 [0:2];

    phase_readout #(.N(3), .BASE(BASE)) u_dut3 (
        .i_clk(clk), .i_rst(rst3), .i_start(start3),
        .i_counter_cutoff(cutoff3), .o_rd_addr(rd_addr3), .i_phase(phase3),
        .o_out_data(data3), .o_out_valid(valid3), .i_out_ready(ready3),
        .o_out_last(last3), .o_busy(busy3), .o_done(done3),
        .o_ones_count(ones3)
    );

    always_comb begin
        int idx;
        idx    = int'((rd_addr3 - BASE) >> 2);
        phase3 = 32'hDEAD_BEEF;
        if (idx >= 0 && idx < 3) phase3 = mem3[idx];
    end

    // ---------------- DUT with N = 40 ----------------
    logic        rst40, start40, ready40, valid40, last40, busy40, done40;
    logic [31:0] cutoff40, rd_addr40, phase40, data40;
    logic [10:0] ones40;

    assign phase40 = 32'd100;

    phase_readout #(.N(40), .BASE(BASE)) u_dut40 (
        .i_clk(clk), .i_rst(rst40), .i_start(start40),
        .i_counter_cutoff(cutoff40), .o_rd_addr(rd_addr40), .i_phase(phase40),
        .o_out_data(data40), .o_out_valid(valid40), .i_out_ready(ready40),
        .o_out_last(last40), .o_busy(busy40), .o_done(done40),
        .o_ones_count(ones40)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One N=3 sweep. stall = cycles out_ready is held low in PUSH.
    // poke: 0 none, 1 start pulsed during READ, 2 start pulsed during DONE.
    task automatic run3(input logic [31:0] cut, input int stall, input int poke,
                        output logic [31:0] word, output logic last,
                        output int lat, output int nbeats, output int ndone);
        int          cyc;
        int          st;
        logic [31:0] held;
        logic        held_last;
        logic        seen;
        cutoff3 = cut;
        ready3  = (stall == 0);
        start3  = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        cyc = 1; st = 0; lat = 0; nbeats = 0; ndone = 0;
        word = '0; last = 1'b0; seen = 1'b0; held = '0; held_last = 1'b0;
        while (cyc < 60) begin
            if (cyc == 3 && !valid3) chk("rd_addr_idx2", rd_addr3, BASE + 32'd8);
            if (poke == 1 && cyc == 1) start3 = 1'b1;
            if (valid3) begin
                if (!seen) begin
                    held = data3; held_last = last3; seen = 1'b1;
                end else begin
                    chk("hold_data", data3, held);
                    chk("hold_last", {31'd0, last3}, {31'd0, held_last});
                    chk("hold_rd_addr", rd_addr3, BASE + 32'd8);
                end
                if (!ready3) begin
                    if (st == stall) ready3 = 1'b1;
                    else st++;
                end
                if (ready3) begin
                    word = data3; last = last3; nbeats++;
                end
            end
            if (done3) begin
                ndone++;
                if (lat == 0) lat = cyc;
                if (poke == 2) start3 = 1'b1;
            end
            if (lat != 0 && cyc >= lat + 3) break;
            @(posedge clk); #1;
            start3 = 1'b0;
            cyc++;
        end
        ready3 = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        logic        l;
        int          lat, nb, nd, cyc;
        logic [31:0] w40 [0:1];
        logic        l40 [0:1];

        rst3 = 1'b1; rst40 = 1'b1;
        start3 = 1'b0; start40 = 1'b0;
        ready3 = 1'b1; ready40 = 1'b1;
        cutoff3 = '0; cutoff40 = '0;
        mem3[0] = 32'd10; mem3[1] = 32'd2; mem3[2] = 32'd5;
        repeat (2) @(posedge clk);
        #1;
        rst3 = 1'b0; rst40 = 1'b0;

        // Reset values
        chk("rst_rd_addr", rd_addr3, BASE);
        chk("rst_out_data", data3, 32'd0);
        chk("rst_out_valid", {31'd0, valid3}, 32'd0);
        chk("rst_out_last", {31'd0, last3}, 32'd0);
        chk("rst_busy", {31'd0, busy3}, 32'd0);
        chk("rst_done", {31'd0, done3}, 32'd0);
        chk("rst_ones", {21'd0, ones3}, 32'd0);

        // Basic N=3 sweep: bits 1,0,1 (5 >= 5 gives 1)
        run3(32'd5, 0, 0, w, l, lat, nb, nd);
        chk("basic_word", w, 32'h0000_0005);
        chk("basic_last", {31'd0, l}, 32'd1);
        chk("basic_beats", nb, 32'd1);
        chk("basic_latency", lat, 32'd5);
        chk("basic_ones", {21'd0, ones3}, 32'd2);
        chk("basic_idle_busy", {31'd0, busy3}, 32'd0);
        chk("basic_idle_addr", rd_addr3, BASE);

        // Backpressure: 3 stalled cycles in PUSH
        run3(32'd5, 3, 0, w, l, lat, nb, nd);
        chk("bp_word", w, 32'h0000_0005);
        chk("bp_last", {31'd0, l}, 32'd1);
        chk("bp_latency", lat, 32'd8);
        chk("bp_beats", nb, 32'd1);

        // cutoff 0, all phases 0
        mem3[0] = 32'd0; mem3[1] = 32'd0; mem3[2] = 32'd0;
        run3(32'd0, 0, 0, w, l, lat, nb, nd);
        chk("cut0_word", w, 32'h0000_0007);
        chk("cut0_ones", {21'd0, ones3}, 32'd3);

        // cutoff max: FFFFFFFE -> 0, FFFFFFFF -> 1
        mem3[0] = 32'hFFFF_FFFE; mem3[1] = 32'hFFFF_FFFF; mem3[2] = 32'hFFFF_FFFF;
        run3(32'hFFFF_FFFF, 0, 0, w, l, lat, nb, nd);
        chk("cutmax_word", w, 32'h0000_0006);
        chk("cutmax_ones", {21'd0, ones3}, 32'd2);

        // start pulsed during READ and during DONE is ignored
        mem3[0] = 32'd10; mem3[1] = 32'd2; mem3[2] = 32'd5;
        run3(32'd5, 0, 1, w, l, lat, nb, nd);
        chk("pokeread_latency", lat, 32'd5);
        chk("pokeread_beats", nb, 32'd1);
        chk("pokeread_dones", nd, 32'd1);
        chk("pokeread_idle", {31'd0, busy3}, 32'd0);
        run3(32'd5, 0, 2, w, l, lat, nb, nd);
        chk("pokedone_beats", nb, 32'd1);
        chk("pokedone_dones", nd, 32'd1);
        chk("pokedone_idle", {31'd0, busy3}, 32'd0);

        // Reset during stalled PUSH
        cutoff3 = 32'd5; ready3 = 1'b0; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        cyc = 1;
        while (!valid3 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rstpush_valid_before", {31'd0, valid3}, 32'd1);
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        chk("rstpush_valid", {31'd0, valid3}, 32'd0);
        chk("rstpush_busy", {31'd0, busy3}, 32'd0);
        chk("rstpush_rd_addr", rd_addr3, BASE);
        chk("rstpush_last", {31'd0, last3}, 32'd0);
        chk("rstpush_done", {31'd0, done3}, 32'd0);
        run3(32'd5, 0, 0, w, l, lat, nb, nd);
        chk("after_rst_word", w, 32'h0000_0005);
        chk("after_rst_latency", lat, 32'd5);
        chk("after_rst_ones", {21'd0, ones3}, 32'd2);

        // N=40, all phases 100, cutoff 50
        cutoff40 = 32'd50; ready40 = 1'b1; start40 = 1'b1;
        @(posedge clk); #1;
        start40 = 1'b0;
        cyc = 1; nb = 0; lat = 0;
        w40[0] = '0; w40[1] = '0; l40[0] = 1'b0; l40[1] = 1'b0;
        while (lat == 0 && cyc < 200) begin
            if (valid40 && ready40) begin
                if (nb < 2) begin
                    w40[nb] = data40; l40[nb] = last40;
                end
                nb++;
            end
            if (done40) lat = cyc;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("n40_beats", nb, 32'd2);
        chk("n40_word0", w40[0], 32'hFFFF_FFFF);
        chk("n40_last0", {31'd0, l40[0]}, 32'd0);
        chk("n40_word1", w40[1], 32'h0000_00FF);
        chk("n40_last1", {31'd0, l40[1]}, 32'd1);
        chk("n40_latency", lat, 32'd43);
        chk("n40_ones", {21'd0, ones40}, 32'd40);
        @(posedge clk); #1;
        chk("n40_idle_busy", {31'd0, busy40}, 32'd0);
        chk("n40_idle_addr", rd_addr40, BASE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_readout.md
# phase_readout

Readout sequencer for the per-spin phase counters held by the sample block. On a start pulse it sweeps the phase read port address by address and compares each counter against a snapshot of the cutoff to produce one spin bit per oscillator. It packs the bits into 32-bit words and streams them out over a valid/ready handshake, with a final popcount. It sits between the sample block's read port and the host-side result FIFO/bus.

## Interface
- N, 3, number of spins/phase counters to sweep (1..1024)
- BASE, `PHASE_ADDR_BASE, byte address of phase counter 0; counter i lives at BASE + 4*i
- clk  input  1  single clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; sampled only in IDLE
- counter_cutoff  input  32  threshold; captured on the accepted start
- rd_addr  output  32  address into the sample block's phase read port
- phase  input  32  counter value for rd_addr; combinational, same cycle
- out_data  output  32  packed spin bits; bit k = spin (32*w + k)
- out_valid  output  1  out_data holds a word
- out_ready  input  1  consumer accepts a word when out_valid && out_ready
- out_last  output  1  qualifies the final word of a sweep
- busy  output  1  high from the cycle after an accepted start through the DONE cycle
- done  output  1  one-cycle pulse at end of sweep
- ones_count  output  11  number of spin bits equal to 1 in the last sweep; stable from done until the next accepted start

## Operation
- FSM states: IDLE, READ, PUSH, DONE.
- IDLE: rd_addr = BASE. When start = 1: capture cutoff, clear index i, the shift word and ones_count, then go to READ. Outputs are otherwise quiet.
- READ (one cycle per index):
  - rd_addr = BASE + (i << 2). The 32-bit add wraps modulo 2^32.
  - bit = (phase >= cutoff_q), unsigned compare. Equality yields 1.
  - Write the bit into word position i[4:0] and add it to ones_count.
  - If i[4:0] == 31 or i == N-1, go to PUSH. Otherwise i++ and stay in READ.
- PUSH:
  - out_valid = 1 and out_data = the assembled word. Unfilled high bits of the last word are 0.
  - out_last = 1 when i == N-1.
  - While waiting for out_ready, out_data and out_last are held stable.
  - On handshake: if last, go to DONE. Otherwise clear the word, i++, and go to READ.
  - rd_addr holds its last value during PUSH.
- DONE: done = 1 for one cycle, then go to IDLE.
- Word count per sweep = ceil(N/32).
- start is ignored outside IDLE. That includes start during DONE.
- Counters keep moving during a sweep. Each bit reflects its counter at its own READ cycle; no atomic snapshot is provided.
- rst in any state takes effect the next edge:
  - State returns to IDLE and any word in flight is dropped.
  - out_valid, out_last, done and busy deassert.

## Timing
- Reset values: rd_addr = BASE; out_data = 0; out_valid = 0; out_last = 0; busy = 0; done = 0; ones_count = 0.
- Start is accepted at edge t0. READ for index 0 runs in cycle t0+1.
- With out_ready held high, total latency from start to done = N + ceil(N/32) + 1 cycles after t0.
  - For N = 3: READ at t0+1..t0+3, PUSH at t0+4, done at t0+5.
- Each cycle out_ready is low in PUSH adds one cycle. No combinational path from out_ready to out_valid.
- phase is sampled in the same cycle rd_addr is driven. The sample block must present it combinationally.
- busy is 0 in IDLE and 1 in READ, PUSH and DONE.

## Test plan
- N=3, cutoff=5, phases {10,2,5}, out_ready=1:
  - out_data=0x00000005, out_last=1 in a single beat.
  - ones_count=2.
  - done pulses 5 cycles after start.
- N=40, all phases 100, cutoff 50:
  - Word 0 = 0xFFFFFFFF with out_last=0.
  - Word 1 = 0x000000FF with out_last=1.
  - ones_count=40.
- Backpressure: in the N=3 case, hold out_ready low for 3 cycles in PUSH.
  - out_valid stays 1 with out_data/out_last stable.
  - done is delayed exactly 3 cycles.
- Boundary compares:
  - cutoff=0 with every phase 0 gives all bits 1.
  - cutoff=0xFFFFFFFF with phases 0xFFFFFFFE/0xFFFFFFFF gives bits 0/1.
- Pulse start during READ and during DONE: no restart, no second done, word count unchanged.
- Assert rst during PUSH with out_valid=1 and out_ready=0:
  - Next cycle out_valid=0, busy=0, rd_addr=BASE.
  - A fresh start then completes normally.
